// File: rtl/concat_packer.sv
// Packs RATIO consecutive IN_W-bit words into one wide word, with selectable slot order,
// partial-word flush and a one-entry output register behind a valid/ready handshake.
module concat_packer #(
  parameter int IN_W      = 2,
  parameter int RATIO     = 2,
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = $clog2(RATIO + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [IN_W-1:0]         in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [IN_W*RATIO-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        out_count
);

  localparam int OUT_W = IN_W * RATIO;

  logic [OUT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_valid_q, out_valid_d;
  logic             flush_pend_q, flush_pend_d;

  logic             accept_s;
  logic             last_s;
  logic             out_free_s;
  logic             load_s;
  logic [CNT_W-1:0] slot_s;
  logic [CNT_W-1:0] fill_s;
  logic [OUT_W-1:0] merged_s;

  // A pending flush counts as a flush request for the stall term, so input stays held off.
  assign in_ready = !(out_valid_q && !out_ready && (last_s || flush || flush_pend_q));

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_count = out_count_q;

  always_comb begin
    accept_s   = in_valid && in_ready;
    last_s     = (cnt_q == CNT_W'(RATIO - 1));
    out_free_s = !out_valid_q || out_ready;
    slot_s     = (MSB_FIRST != 0) ? (CNT_W'(RATIO - 1) - cnt_q) : cnt_q;
    fill_s     = cnt_q + CNT_W'(accept_s);

    merged_s = acc_q;
    for (int s = 0; s < RATIO; s++) begin
      if (accept_s && (slot_s == CNT_W'(s))) begin
        merged_s[s*IN_W +: IN_W] = in_data;
      end else begin
        merged_s[s*IN_W +: IN_W] = acc_q[s*IN_W +: IN_W];
      end
    end

    // Flush only fires when something is held and the output register can take it.
    load_s = (accept_s && last_s) ||
             ((flush || flush_pend_q) && out_free_s &&
              ((cnt_q != {CNT_W{1'b0}}) || accept_s));

    acc_d        = acc_q;
    cnt_d        = cnt_q;
    out_data_d   = out_data_q;
    out_count_d  = out_count_q;
    out_valid_d  = out_valid_q;
    flush_pend_d = flush_pend_q;

    if (load_s) begin
      out_data_d   = merged_s;
      out_count_d  = fill_s;
      out_valid_d  = 1'b1;
      acc_d        = {OUT_W{1'b0}};
      cnt_d        = {CNT_W{1'b0}};
      flush_pend_d = 1'b0;
    end else begin
      if (accept_s) begin
        acc_d = merged_s;
        cnt_d = fill_s;
      end else begin
        acc_d = acc_q;
      end
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end else begin
        out_valid_d = out_valid_q;
      end
      if (flush && !out_free_s && (cnt_q != {CNT_W{1'b0}})) begin
        flush_pend_d = 1'b1;
      end else begin
        flush_pend_d = flush_pend_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q        <= {OUT_W{1'b0}};
      cnt_q        <= {CNT_W{1'b0}};
      out_data_q   <= {OUT_W{1'b0}};
      out_count_q  <= {CNT_W{1'b0}};
      out_valid_q  <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      out_data_q   <= out_data_d;
      out_count_q  <= out_count_d;
      out_valid_q  <= out_valid_d;
      flush_pend_q <= flush_pend_d;
    end
  end

endmodule
